// File: rtl/demux_1_4_behav_always.sv
`default_nettype none
// ============================================================================
//  Module      : demux_1_4_behav_always
//  Description : Registered 1-to-4 demultiplexer. Data input A is steered to
//                exactly one of Y1..Y4 by the select {S2,S1}; the three
//                unselected outputs are driven to zero. Outputs are
//                registered on clk and cleared asynchronously by rst.
//
//  Ports       : clk        - system clock, rising-edge active
//                rst        - asynchronous active-high reset
//                A  [W-1:0] - data to be routed
//                S2         - select MSB
//                S1         - select LSB
//                Y1 [W-1:0] - A when {S2,S1}=00, else 0
//                Y2 [W-1:0] - A when {S2,S1}=01, else 0
//                Y3 [W-1:0] - A when {S2,S1}=10, else 0
//                Y4 [W-1:0] - A when {S2,S1}=11, else 0
//
//  Parameters  : WIDTH      - bit width of A and of each output (>= 1)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_1_4_behav_always #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic             S2,
    input  logic             S1,
    output logic [WIDTH-1:0] Y1,
    output logic [WIDTH-1:0] Y2,
    output logic [WIDTH-1:0] Y3,
    output logic [WIDTH-1:0] Y4
);

    // Next-state values for the four output registers.
    logic [WIDTH-1:0] w_y1_next;
    logic [WIDTH-1:0] w_y2_next;
    logic [WIDTH-1:0] w_y3_next;
    logic [WIDTH-1:0] w_y4_next;

    // Output registers; these are the only state in the block.
    logic [WIDTH-1:0] r_y1;
    logic [WIDTH-1:0] r_y2;
    logic [WIDTH-1:0] r_y3;
    logic [WIDTH-1:0] r_y4;

    // Select decode. Every next-output starts at zero, so unselected outputs
    // are always cleared rather than held. The default branch catches
    // non-binary selects (X/Z in simulation) and routes nothing.
    always_comb begin
        w_y1_next = '0;
        w_y2_next = '0;
        w_y3_next = '0;
        w_y4_next = '0;
        case ({S2, S1})
            2'b00:   w_y1_next = A;
            2'b01:   w_y2_next = A;
            2'b10:   w_y3_next = A;
            2'b11:   w_y4_next = A;
            default: begin
                w_y1_next = '0;
                w_y2_next = '0;
                w_y3_next = '0;
                w_y4_next = '0;
            end
        endcase
    end

    // Registering the outputs keeps select changes between edges from
    // glitching the consumers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y1 <= '0;
            r_y2 <= '0;
            r_y3 <= '0;
            r_y4 <= '0;
        end else begin
            r_y1 <= w_y1_next;
            r_y2 <= w_y2_next;
            r_y3 <= w_y3_next;
            r_y4 <= w_y4_next;
        end
    end

    assign Y1 = r_y1;
    assign Y2 = r_y2;
    assign Y3 = r_y3;
    assign Y4 = r_y4;

endmodule
`default_nettype wire

// File: tb/tb_demux_1_4_behav_always.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_1_4_behav_always
//  Description : Self-checking bench for demux_1_4_behav_always (WIDTH=8).
//                A reference model remembers the last routed (select, data)
//                pair and derives every output from it; a compare process
//                checks all four outputs each falling edge. Directed literal
//                checks cover reset, select sweep, zero data, latency and
//                asynchronous reset, followed by randomized traffic.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1_4_behav_always;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] a   = '0;
    logic         s2  = 1'b0;
    logic         s1  = 1'b0;
    logic [W-1:0] y1, y2, y3, y4;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    demux_1_4_behav_always #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .A   (a),
        .S2  (s2),
        .S1  (s1),
        .Y1  (y1),
        .Y2  (y2),
        .Y3  (y3),
        .Y4  (y4)
    );

    always #5 clk = ~clk;

    // Reference model: which output (0..3) currently holds data and what
    // that data is. Everything else is zero by definition.
    int           m_sel  = 0;
    logic [W-1:0] m_data = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sel  <= 0;
            m_data <= '0;
        end else begin
            m_sel  <= 2 * int'(s2) + int'(s1);
            m_data <= a;
        end
    end

    function automatic logic [W-1:0] model_out(input int k);
        return (k == m_sel) ? m_data : '0;
    endfunction

    function automatic logic [W-1:0] dut_out(input int k);
        case (k)
            0:       return y1;
            1:       return y2;
            2:       return y3;
            default: return y4;
        endcase
    endfunction

    task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, got, want);
        end
    endtask

    task automatic check_all(input string nm, input logic [W-1:0] e1, input logic [W-1:0] e2,
                             input logic [W-1:0] e3, input logic [W-1:0] e4);
        check({nm, ".Y1"}, y1, e1);
        check({nm, ".Y2"}, y2, e2);
        check({nm, ".Y3"}, y3, e3);
        check({nm, ".Y4"}, y4, e4);
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("model.Y%0d", k + 1), dut_out(k), model_out(k));
            end
        end
    end

    task automatic drive(input logic [W-1:0] d, input int sel);
        a  = d;
        s2 = sel[1];
        s1 = sel[0];
    endtask

    // Wait for the next falling edge, then move slightly past it to drive.
    task automatic to_drive_point();
        @(negedge clk);
        #2;
    endtask

    initial begin
        // Reset with data present and no clock edge yet: outputs must be 0.
        drive(8'h01, 0);
        #1;
        check_all("reset_noedge", 8'h00, 8'h00, 8'h00, 8'h00);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("reset_release", 8'h01, 8'h00, 8'h00, 8'h00);
        cmp_en = 1'b1;

        // Select sweep with A=1.
        for (int s = 0; s < 4; s++) begin
            to_drive_point();
            drive(8'h01, s);
            @(posedge clk);
            #1;
            check_all($sformatf("sweep%0d", s),
                      (s == 0) ? 8'h01 : 8'h00, (s == 1) ? 8'h01 : 8'h00,
                      (s == 2) ? 8'h01 : 8'h00, (s == 3) ? 8'h01 : 8'h00);
        end

        // Zero data routes nothing, whatever the select.
        for (int s = 0; s < 4; s++) begin
            to_drive_point();
            drive(8'h00, s);
            @(posedge clk);
            #1;
            check_all($sformatf("zero%0d", s), 8'h00, 8'h00, 8'h00, 8'h00);
        end

        // Latency: select change just after an edge waits for the next edge.
        to_drive_point();
        drive(8'h01, 0);
        @(posedge clk);
        #1;
        drive(8'h01, 3);
        #2;
        check_all("latency_hold", 8'h01, 8'h00, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        check_all("latency_move", 8'h00, 8'h00, 8'h00, 8'h01);

        // Full-width routing.
        to_drive_point();
        drive(8'hA5, 1);
        @(posedge clk);
        #1;
        check_all("wide_a5", 8'h00, 8'hA5, 8'h00, 8'h00);

        // Asynchronous reset pulse between edges.
        to_drive_point();
        drive(8'h01, 2);
        @(posedge clk);
        #1;
        check_all("mid_pre", 8'h00, 8'h00, 8'h01, 8'h00);
        #1;
        rst = 1'b1;
        #1;
        check_all("mid_async", 8'h00, 8'h00, 8'h00, 8'h00);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("mid_release", 8'h00, 8'h00, 8'h01, 8'h00);

        // Randomized traffic with occasional reset pulses.
        for (int i = 0; i < 300; i++) begin
            to_drive_point();
            drive(($urandom_range(0, 7) == 0) ? 8'h00 : W'($urandom), int'($urandom_range(0, 3)));
            rst = ($urandom_range(0, 29) == 0);
        end
        to_drive_point();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
